// File: rtl/gray_conv_arbiter_if.sv
// Requester/result bundle for gray_conv_arbiter: four valid/ready lanes in, one registered result out.
// master drives requests and out_ready; slave is the arbiter.
interface gray_conv_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_gray;
  logic [DW-1:0]       out_bin;
  logic [ID_W-1:0]     out_id;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_gray, out_bin, out_id
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_gray, out_bin, out_id
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin 4:1 arbiter feeding one binary-to-Gray converter; 1-cycle latency, full throughput.
// Backpressure: a held result (out_valid & !out_ready) freezes out_* and forces req_ready to 0.
module gray_conv_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 4,
  parameter int ID_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  gray_conv_arbiter_if.slave  bus
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  typedef struct packed {
    logic [DW-1:0]   gray;
    logic [DW-1:0]   bin;
    logic [ID_W-1:0] id;
  } result_t;

  state_t           r_state;
  state_t           w_state_nxt;
  result_t          r_res;
  logic [ID_W-1:0]  r_last_id;

  logic [ID_W-1:0]  w_idx;
  logic [ID_W-1:0]  w_win;
  logic             w_any;
  logic             w_free;
  logic             w_accept;
  logic [DW-1:0]    w_bin;
  logic [DW-1:0]    w_gray;
  logic [N_REQ-1:0] w_req_ready;

  // Search starts just after the last winner; offset N_REQ wraps back onto last_id itself.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = r_last_id + ID_W'(k);
      if (!w_any && bus.req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_bin       = bus.req_data[w_win*DW +: DW];
  assign w_gray      = w_bin ^ {1'b0, w_bin[DW-1:1]};
  assign w_free      = ((r_state == S_EMPTY) || bus.out_ready) && !rst;
  assign w_accept    = w_any && w_free;
  assign w_req_ready = w_accept ? (N_REQ'(1) << w_win) : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
      S_FULL: begin
        if (w_accept)          w_state_nxt = S_FULL;
        else if (bus.out_ready) w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Result fields only move on accept, so a drain leaves the last word visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_EMPTY;
      r_res     <= '0;
      r_last_id <= '1;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_res     <= '{gray: w_gray, bin: w_bin, id: w_win};
        r_last_id <= w_win;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.out_valid = (r_state == S_FULL);
  assign bus.out_gray  = r_res.gray;
  assign bus.out_bin   = r_res.bin;
  assign bus.out_id    = r_res.id;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: reference model checked every cycle plus directed literal scenarios.
module tb_gray_conv_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gray_conv_arbiter_if bus ();

  gray_conv_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the rules, not the RTL structure.
  logic       m_valid;
  logic [3:0] m_gray;
  logic [3:0] m_bin;
  logic [1:0] m_id;
  int         m_last;
  int         m_w;

  function automatic int pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++)
      if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] exp_ready();
    int w;
    if (rst) return 4'h0;
    w = pick(bus.req_valid, m_last);
    if (w < 0 || (m_valid && !bus.out_ready)) return 4'h0;
    return 4'(1 << w);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      m_gray  = 4'h0;
      m_bin   = 4'h0;
      m_id    = 2'd0;
      m_last  = 3;
    end else begin
      m_w = pick(bus.req_valid, m_last);
      if (m_w >= 0 && (!m_valid || bus.out_ready)) begin
        m_bin   = bus.req_data[m_w*4 +: 4];
        m_gray  = to_gray(m_bin);
        m_id    = 2'(m_w);
        m_valid = 1'b1;
        m_last  = m_w;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_out_valid", 8'(bus.out_valid), 8'(m_valid));
    check("cyc_out_gray",  8'(bus.out_gray),  8'(m_gray));
    check("cyc_out_bin",   8'(bus.out_bin),   8'(m_bin));
    check("cyc_out_id",    8'(bus.out_id),    8'(m_id));
    check("cyc_req_ready", 8'(bus.req_ready), 8'(exp_ready()));
  end

  logic [3:0] sweep_gray [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  logic [3:0] rr_gray [4]     = '{4'h1, 4'h7, 4'hF, 4'h8};
  int         wt [4]          = '{default: 0};
  logic [3:0] acc;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 4'h0;
    bus.req_data  = 16'h0;
    bus.out_ready = 1'b0;

    // Reset with everything requesting
    #1;
    rst           = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_data  = {4'hF, 4'hA, 4'h5, 4'h1};
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 8'(bus.out_valid), 8'd0);
    check("rst_out_gray",  8'(bus.out_gray),  8'h0);
    check("rst_out_id",    8'(bus.out_id),    8'd0);
    check("rst_req_ready", 8'(bus.req_ready), 8'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Round-robin over four constant requesters
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("rr_valid", 8'(bus.out_valid), 8'd1);
      check("rr_id",    8'(bus.out_id),    8'(i % 4));
      check("rr_gray",  8'(bus.out_gray),  8'(rr_gray[i % 4]));
    end

    // Requester 2 alone streams 0..15
    for (int v = 0; v < 16; v++) begin
      bus.req_valid = 4'b0100;
      bus.req_data  = {4'h0, 4'(v), 8'h00};
      @(posedge clk); #1;
      check("sweep_valid", 8'(bus.out_valid), 8'd1);
      check("sweep_id",    8'(bus.out_id),    8'd2);
      check("sweep_gray",  8'(bus.out_gray),  8'(sweep_gray[v]));
    end
    bus.req_valid = 4'h0;
    @(posedge clk); #1;
    check("idle_valid", 8'(bus.out_valid), 8'd0);

    // Backpressure: hold a result from requester 1 for five cycles
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0010;
    bus.req_data  = {4'h9, 4'h0, 4'h6, 4'h0};
    @(posedge clk); #1;
    bus.req_valid = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_valid", 8'(bus.out_valid), 8'd1);
      check("bp_id",    8'(bus.out_id),    8'd1);
      check("bp_gray",  8'(bus.out_gray),  8'h5);
      check("bp_bin",   8'(bus.out_bin),   8'h6);
      check("bp_ready", 8'(bus.req_ready), 8'h0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_grant", 8'(bus.req_ready), 8'b1000);
    @(posedge clk); #1;
    check("bp_next_valid", 8'(bus.out_valid), 8'd1);
    check("bp_next_id",    8'(bus.out_id),    8'd3);
    check("bp_next_gray",  8'(bus.out_gray),  8'hD);
    bus.req_valid = 4'b0010;
    @(posedge clk); #1;
    check("bp_after_id",   8'(bus.out_id),    8'd1);
    check("bp_after_gray", 8'(bus.out_gray),  8'h5);

    // Skip: requester 1 withdraws while stalled
    bus.req_valid = 4'b0001;
    bus.req_data  = {4'h0, 4'h3, 4'h0, 4'h0};
    @(posedge clk); #1;
    check("skip_pre_id", 8'(bus.out_id), 8'd0);
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0110;
    @(posedge clk); #1;
    bus.req_valid = 4'b0100;
    @(posedge clk); #1;
    check("skip_stall_id", 8'(bus.out_id), 8'd0);
    bus.out_ready = 1'b1;
    #1;
    check("skip_ready", 8'(bus.req_ready), 8'b0100);
    @(posedge clk); #1;
    check("skip_id",   8'(bus.out_id),   8'd2);
    check("skip_gray", 8'(bus.out_gray), 8'h2);
    bus.req_valid = 4'b0011;
    @(posedge clk); #1;
    check("skip_wrap_id", 8'(bus.out_id), 8'd0);

    // Random traffic: no waiting requester sees more than 3 other accepts
    bus.req_valid = 4'h0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.out_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < 4; i++) begin
        if (!bus.req_valid[i] && ($urandom_range(1) == 1)) begin
          bus.req_valid[i]       = 1'b1;
          bus.req_data[i*4 +: 4] = 4'($urandom_range(15));
        end
      end
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      if (acc != 4'h0) begin
        for (int i = 0; i < 4; i++) begin
          if (acc[i]) begin
            wt[i] = 0;
          end else if (bus.req_valid[i]) begin
            wt[i]++;
            check("fair_wait", 8'(wt[i] <= 3), 8'd1);
          end
        end
      end
      @(posedge clk); #1;
      bus.req_valid = bus.req_valid & ~acc;
    end

    // Asynchronous reset while FULL
    bus.req_valid = 4'h0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0100;
    bus.req_data  = 16'h0700;
    @(posedge clk); #1;
    check("mr_full_valid", 8'(bus.out_valid), 8'd1);
    check("mr_full_id",    8'(bus.out_id),    8'd2);
    bus.req_valid = 4'b1010;
    bus.req_data  = {4'h9, 4'h7, 4'h3, 4'h0};
    #2;
    rst = 1'b1;
    #1;
    check("mr_valid", 8'(bus.out_valid), 8'd0);
    check("mr_ready", 8'(bus.req_ready), 8'h0);
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("mr_restart_valid", 8'(bus.out_valid), 8'd1);
    check("mr_restart_id",    8'(bus.out_id),    8'd1);
    check("mr_restart_gray",  8'(bus.out_gray),  8'h2);

    bus.req_valid = 4'h0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

Round-robin arbiter that shares one 4-bit binary-to-Gray conversion datapath between four independent requesters. Each requester offers a 4-bit binary word through a valid/ready handshake. One word is accepted per cycle, converted, and registered into a single output stage together with the requester ID. The output stage has its own valid/ready handshake. The block sits between the producers of binary codes (counters, address generators) and a single downstream Gray-code consumer.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters; fixed at 4 in this revision. `ID_W` = 2.
- `DW`, 4, data width; fixed at 4 to match the converter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 4: bit i set means requester i offers data.
- `req_data` in 16: lane i is `req_data[4i+3:4i]`, binary word of requester i.
- `req_ready` out 4: bit i set means requester i is accepted this cycle if `req_valid[i]`; at most one bit set.
- `out_valid` out 1: output register holds a result.
- `out_ready` in 1: downstream accepts the result this cycle.
- `out_gray` out 4: Gray code of the accepted word.
- `out_bin` out 4: original binary word, retained for checking.
- `out_id` out 2: index of the requester that supplied the word.

## Operation
- Gray conversion: `g[3]=b[3]`, `g[2]=b[3]^b[2]`, `g[1]=b[2]^b[1]`, `g[0]=b[1]^b[0]`. It is computed on the granted lane before the output register.
- Output stage FSM:
  - EMPTY (`out_valid=0`)
  - FULL (`out_valid=1`)
- Stage free condition: `free = !out_valid | out_ready`.
- Arbitration is combinational each cycle:
  - Search `req_valid` starting at `(last_id+1) mod 4` and wrapping.
  - The first set bit wins.
  - `req_ready[win] = free`; all other `req_ready` bits are 0.
  - With no valid request, `req_ready = 0`.
- `req_ready` may depend combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- Accept = `req_valid[win] & req_ready[win]`. On accept, at the clock edge:
  - Load `out_gray`, `out_bin` and `out_id=win`.
  - Set `out_valid=1`.
  - Set `last_id=win`.
- Drain without accept (`out_valid & out_ready & no accept`):
  - Clear `out_valid`.
  - `out_gray`, `out_bin` and `out_id` hold their last values.
- FSM transitions:
  - EMPTY→FULL on accept.
  - FULL→FULL on accept with `out_ready`, which is a simultaneous drain and load.
  - FULL→EMPTY on drain without accept.
  - FULL holds when `out_ready=0`; `req_ready` is then forced to 0.
- `last_id` changes only on accept. A requester that drops `req_valid` before acceptance is skipped without penalty.
- Fairness: a requester holding `req_valid` is accepted within at most 4 accepts.
- Requesters hold `req_valid` and data stable until accepted. Behaviour on violation is undefined but must not corrupt `out_*` of an already-loaded result.

## Timing
- Reset values: `out_valid=0`, `out_gray=0`, `out_bin=0`, `out_id=0`, `last_id=3` (so requester 0 has first priority), `req_ready=0` while `rst` is high.
- Latency: a word accepted at edge t is visible on `out_*` with `out_valid=1` right after edge t. That is one cycle from `req_valid` to `out_valid`.
- Throughput: one word per cycle while `out_ready=1`. There are no bubbles on simultaneous drain and load.
- Backpressure: while `out_valid=1` and `out_ready=0`, all `out_*` outputs are stable and `req_ready=0`.
- Reset mid-operation: `rst` asserted in any cycle clears `out_valid` immediately (asynchronous), and the pending result is discarded. The first grant after release goes to the lowest-indexed valid requester.
- Release is synchronised externally; there is no accept on the cycle `rst` is high.

## Test plan
- Reset check:
  - Stimulus: assert `rst` with `req_valid=4'hF`, `out_ready=1`.
  - Required: `out_valid=0`, `out_gray=0`, `out_id=0`, `req_ready=0`.
  - After release, the first result has `out_id=0`.
- Conversion sweep:
  - Stimulus: requester 2 alone streams binary 0..15 with `out_ready=1`.
  - Required: `out_gray` = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, with `out_id=2` throughout.
  - Required: one result per cycle, first result one cycle after the first `req_valid`.
- Round-robin:
  - Stimulus: all four valid continuously with data 4'h1, 4'h5, 4'hA, 4'hF and `out_ready=1`.
  - Required: `out_id` sequence 0,1,2,3,0,…; matching gray 1,7,F,8.
- Backpressure:
  - Stimulus: `out_ready=0` for 5 cycles with `out_valid=1`.
  - Required: `out_*` stable and `req_ready=0` for all 5 cycles.
  - Then raise `out_ready` with requesters 1 and 3 valid after last grant 1. Required: the next `out_id` is 3 on the same edge as the drain, with no bubble.
- Skip and fairness:
  - Stimulus: requester 1 drops valid before being granted.
  - Required: the grant proceeds to the next valid index and `last_id` updates only on accept.
  - Over a random run, no waiting requester waits more than 4 accepts.
- Reset mid-stream:
  - Stimulus: assert `rst` asynchronously between edges while FULL.
  - Required: `out_valid` falls before the next edge; after release, arbitration restarts at requester 0.
